// File: rtl/if_fetch_predict.sv
// Fetch stage: PC register, I-cache address and BTB + 2-bit counter branch prediction.
// Optional macro PRED_STATS_EN builds saturating resolved-branch / redirect counters.
module if_fetch_predict #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BTB_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write_en,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_plus4_out,
    output logic        pred_taken_out,
    output logic        fetch_valid,
    input  logic        ex_update_en,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_redirect_en,
    input  logic [31:0] ex_redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);
    localparam int unsigned ENTRIES   = 1 << BTB_IDX_W;
    localparam int unsigned TAG_W     = 32 - BTB_IDX_W - 2;
    localparam logic [1:0]  CTR_RESET = 2'b01;
    localparam logic [1:0]  CTR_ALLOC = 2'b10;
    localparam logic [1:0]  CTR_MAX   = 2'b11;
    localparam logic [1:0]  CTR_MIN   = 2'b00;

    logic [31:0]          pc_q, pc_d;
    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [31:0]          target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];

    logic [BTB_IDX_W-1:0] idx;
    logic [TAG_W-1:0]     pc_tag;
    logic                 hit;

    logic [BTB_IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0]     ex_tag;
    logic                 ex_hit;
    logic                 upd_we;
    logic [31:0]          upd_target_d;
    logic [1:0]           upd_ctr_d;

    logic                 unused_pc_bits;
    assign unused_pc_bits = ^ex_pc[1:0];

    // Lookup on the registered PC; sees the table as it stood before this edge.
    assign idx            = pc_q[BTB_IDX_W+1:2];
    assign pc_tag         = pc_q[31:BTB_IDX_W+2];
    assign hit            = valid_q[idx] && (tag_q[idx] == pc_tag);
    assign pred_taken_out = hit & ctr_q[idx][1];

    assign imem_addr      = pc_q;
    assign pc_plus4_out   = pc_q + 32'd4;
    assign fetch_valid    = imem_ready & ~ex_redirect_en;

    // Redirect beats stall and miss; a taken prediction beats sequential fetch.
    always_comb begin
        pc_d = pc_q;
        if (ex_redirect_en) begin
            pc_d = ex_redirect_pc;
        end else if (!pc_write_en || !imem_ready) begin
            pc_d = pc_q;
        end else if (pred_taken_out) begin
            pc_d = target_q[idx];
        end else begin
            pc_d = pc_plus4_out;
        end
    end

    assign ex_idx = ex_pc[BTB_IDX_W+1:2];
    assign ex_tag = ex_pc[31:BTB_IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Resolution update: train on hit, allocate only on a taken miss.
    always_comb begin
        upd_we       = 1'b0;
        upd_target_d = target_q[ex_idx];
        upd_ctr_d    = ctr_q[ex_idx];
        if (ex_update_en) begin
            if (ex_hit) begin
                upd_we = 1'b1;
                if (ex_taken) begin
                    upd_target_d = ex_target;
                    upd_ctr_d    = (ctr_q[ex_idx] == CTR_MAX) ? CTR_MAX : 2'(ctr_q[ex_idx] + 2'd1);
                end else begin
                    upd_ctr_d    = (ctr_q[ex_idx] == CTR_MIN) ? CTR_MIN : 2'(ctr_q[ex_idx] - 2'd1);
                end
            end else if (ex_taken) begin
                upd_we       = 1'b1;
                upd_target_d = ex_target;
                upd_ctr_d    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (upd_we) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= upd_target_d;
            ctr_q[ex_idx]    <= upd_ctr_d;
        end
    end

`ifdef PRED_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    // Saturating event counters.
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (ex_update_en && (stat_br_q != 32'hFFFF_FFFF)) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (ex_redirect_en && (stat_mp_q != 32'hFFFF_FFFF)) begin
            stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule
